onehot_grant_mux: RTL and testbench
===================================

Name: onehot_grant_mux

Overview:
- Combined request arbiter and one-hot data selector for the bus fabric's N:1 arbiters.
- Produces a one-hot grant from a request vector using strict lowest-index priority.
- When `canchange` is asserted, the grant instead rotates past the most recently granted port.
- Muxes a packed data vector using that grant, for address-phase signal passthrough.

Parameters:
- N_PORTS, 2, number of requesters/data inputs (≥1).
- W_DATA, 32, width of each data slice.
- W_IDX, $clog2(N_PORTS) (minimum 1), width of the internal last-grant index. Derived localparam, not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- canchange  in  1  permission to rotate the grant away from the last-granted port.
- req  in  N_PORTS  request vector; bit i = port i requests.
- gnt  out  N_PORTS  one-hot (or zero) grant, combinational.
- data_in  in  N_PORTS*W_DATA  packed inputs; slice i = data_in[i*W_DATA +: W_DATA].
- data_out  out  W_DATA  selected data.
- last_idx  out  W_IDX  registered index of the most recent nonzero grant.

Interface:
- One clock (clk).
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: last_idx=0. gnt and data_out are combinational, so they are 0 whenever req=0.
- Priority mode (canchange=0):
  - gnt = lowest-index set bit of req; lower index = higher priority.
  - req=0 → gnt=0.
- Rotate mode (canchange=1):
  - If any req bit has index > last_idx, gnt = lowest such bit.
  - Otherwise wrap: gnt = lowest set bit overall, which may equal last_idx.
  - req=0 → gnt=0.
- gnt is never multi-hot. gnt[i]=1 implies req[i]=1.
- last_idx update:
  - Loads the index of the set gnt bit on every posedge clk where gnt≠0.
  - Holds when gnt=0.
  - Asynchronous reset mid-operation clears it immediately.
- Zero-latency: no cycle delay from req/canchange to gnt; the only state is last_idx.
- N_PORTS=1: gnt=req; last_idx stays 0; data_out = data_in gated by req.
- Mux:
  - data_out = OR over i of (data_in slice i AND replicate(gnt[i])).
  - gnt=0 → data_out=0.
- Mux in standalone use: a multi-hot selection yields the bitwise OR of the selected slices (only reachable through the sub-module, since gnt is one-hot).
- No X propagation from unselected slices.

Optional Feature:
- ONEHOT_STRICT_SEL_EN:
  - Defined: the mux sub-module drives all-zero output when its select is not exactly one-hot (zero or multi-hot). It also exposes combinational sel_err=1 in that case; the top ties this off unused.
  - Undefined: OR-combining behaviour as above, and sel_err is absent.

Decomposition:
- Shared package onehot_pkg holds:
  - function clog2_min1(n);
  - function lowest_set(vec), returning a one-hot vector;
  - function onehot_to_idx(vec).
- One sub-module, onehot_sel_mux (parameters W_INPUT, N_INPUTS; ports in, sel, out), instantiated once with sel=gnt.
- Arbitration logic stays in the top module.

Test Plan:
- Reset with req=4'b0000, canchange=0, N_PORTS=4 → gnt=0, data_out=0, last_idx=0.
- canchange=0, req=4'b1010, data_in={D,C,B,A}={0x44,0x33,0x22,0x11} → gnt=4'b0010, data_out=0x22; after posedge last_idx=1.
- last_idx=1, canchange=1, req=4'b1010 → gnt=4'b1000, data_out=0x44; after posedge last_idx=3. With canchange held at 1, the next cycle wraps to gnt=4'b0010.
- last_idx=3, canchange=1, req=4'b1000 → gnt=4'b1000 (wrap to same port); last_idx stays 3.
- req=0 for several cycles after last_idx=2 → gnt=0, data_out=0, last_idx holds 2. Assert rst_n=0 mid-cycle → last_idx=0 asynchronously.
- onehot_sel_mux standalone, sel=2'b11, in={0x0F0,0x00F}:
  - without ONEHOT_STRICT_SEL_EN → out=0x0FF;
  - with it → out=0, sel_err=1.

Source files
------------

// File: rtl/onehot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_pkg
//  Description : Shared helpers for the one-hot grant arbiter and selector:
//                minimum-one clog2, lowest-set-bit isolation and one-hot to
//                index conversion. Vector helpers work on a fixed maximum
//                width; callers zero-pad narrower vectors.
//  Revision    : 1.0  initial release
// ============================================================================
package onehot_pkg;

    // Widest request vector the helpers support.
    localparam int C_MAX_PORTS = 64;
    localparam int C_MAX_IDX_W = 6;

    // Ceiling log2, never less than 1 so index ports always have a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Isolate the lowest set bit: two's-complement trick, result is one-hot
    // or zero.
    function automatic logic [C_MAX_PORTS-1:0] lowest_set(input logic [C_MAX_PORTS-1:0] vec);
        return vec & (~vec + {{(C_MAX_PORTS-1){1'b0}}, 1'b1});
    endfunction

    // Index of the set bit of a one-hot vector (zero for an all-zero input).
    function automatic logic [C_MAX_IDX_W-1:0] onehot_to_idx(input logic [C_MAX_PORTS-1:0] vec);
        logic [C_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < C_MAX_PORTS; i++) begin
            if (vec[i]) begin
                idx = idx | C_MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_sel_mux
//  Description : AND-OR selector over N_INPUTS packed slices of W_INPUT bits.
//                A multi-hot select ORs the chosen slices together.
//                Compile macro ONEHOT_STRICT_SEL_EN: when defined, the output
//                is forced to zero unless sel is exactly one-hot, and the
//                sel_err port flags that condition.
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_sel_mux
    import onehot_pkg::*;
#(
    parameter int W_INPUT  = 32,
    parameter int N_INPUTS = 2
) (
    input  logic [N_INPUTS*W_INPUT-1:0] in,
    input  logic [N_INPUTS-1:0]         sel,
`ifdef ONEHOT_STRICT_SEL_EN
    output logic                        sel_err,
`endif
    output logic [W_INPUT-1:0]          out
);

    logic [W_INPUT-1:0] w_or_sel;

    // AND each slice with its replicated select bit and OR the results;
    // unselected slices are masked so their X/garbage never leaks out.
    always_comb begin
        w_or_sel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            w_or_sel = w_or_sel | (in[i*W_INPUT +: W_INPUT] & {W_INPUT{sel[i]}});
        end
    end

`ifdef ONEHOT_STRICT_SEL_EN
    logic w_sel_onehot;

    // Exactly one bit set: nonzero and clearing the lowest bit leaves zero.
    always_comb begin
        w_sel_onehot = (sel != '0) && ((sel & (sel - N_INPUTS'(1))) == '0);
        sel_err      = ~w_sel_onehot;
        out          = w_sel_onehot ? w_or_sel : '0;
    end
`else
    assign out = w_or_sel;
`endif

endmodule
`default_nettype wire

// File: rtl/onehot_grant_mux.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_grant_mux
//  Description : N:1 arbiter with combinational one-hot grant and grant-
//                selected data passthrough. Lowest index wins; with canchange
//                the search starts just past the last granted port and wraps.
//                N_PORTS is limited to onehot_pkg::C_MAX_PORTS (64).
//                Compile macro ONEHOT_STRICT_SEL_EN selects the strict mux
//                variant (grant is always one-hot or zero, so the data path
//                is unaffected; the mux error flag is left unused).
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_grant_mux
    import onehot_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int W_DATA  = 32,
    localparam int W_IDX  = clog2_min1(N_PORTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      canchange,
    input  logic [N_PORTS-1:0]        req,
    output logic [N_PORTS-1:0]        gnt,
    input  logic [N_PORTS*W_DATA-1:0] data_in,
    output logic [W_DATA-1:0]         data_out,
    output logic [W_IDX-1:0]          last_idx
);

    logic [W_IDX-1:0]       r_last_idx;
    logic [C_MAX_PORTS-1:0] w_req_pad;
    logic [C_MAX_PORTS-1:0] w_above_pad;
    logic [C_MAX_PORTS-1:0] w_pick;
    logic [C_MAX_PORTS-1:0] w_gnt_pad;
    logic [N_PORTS-1:0]     w_gnt;
    logic [W_IDX-1:0]       w_gnt_idx;
    logic                   w_unused_pick;

    // Pad requests to helper width and collect those strictly above the
    // last granted index (candidates for the rotating search).
    always_comb begin
        w_req_pad   = '0;
        w_above_pad = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_req_pad[i]   = req[i];
            w_above_pad[i] = req[i] && (i > int'(r_last_idx));
        end
    end

    // Rotate past the last grant when permitted and something lies above it;
    // otherwise (or on wrap) the lowest requester overall wins.
    always_comb begin
        if (canchange && (w_above_pad != '0)) begin
            w_pick = lowest_set(w_above_pad);
        end else begin
            w_pick = lowest_set(w_req_pad);
        end
    end

    // Narrow the padded pick back to port width; padding bits are always zero.
    always_comb begin
        w_gnt     = w_pick[N_PORTS-1:0];
        w_gnt_pad = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_gnt_pad[i] = w_gnt[i];
        end
        w_gnt_idx = W_IDX'(onehot_to_idx(w_gnt_pad));
    end

    assign w_unused_pick = ^w_pick;

    // Remember the most recent nonzero grant; idle cycles hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_idx <= '0;
        end else if (w_gnt != '0) begin
            r_last_idx <= w_gnt_idx;
        end
    end

    assign gnt      = w_gnt;
    assign last_idx = r_last_idx;

`ifdef ONEHOT_STRICT_SEL_EN
    logic w_unused_sel_err;
`endif

    onehot_sel_mux #(
        .W_INPUT  (W_DATA),
        .N_INPUTS (N_PORTS)
    ) u_sel_mux (
        .in      (data_in),
        .sel     (w_gnt),
`ifdef ONEHOT_STRICT_SEL_EN
        .sel_err (w_unused_sel_err),
`endif
        .out     (data_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_onehot_grant_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_grant_mux
//  Description : Self-checking bench for onehot_grant_mux (N_PORTS=4,
//                W_DATA=8) and a standalone onehot_sel_mux. Directed vector
//                table, async-reset sequence, then random traffic against a
//                cyclic-search reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_onehot_grant_mux;

    localparam int NP = 4;
    localparam int WD = 8;

    logic            clk;
    logic            rst_n;
    logic            canchange;
    logic [NP-1:0]   req;
    logic [NP-1:0]   gnt;
    logic [NP*WD-1:0] data_in;
    logic [WD-1:0]   data_out;
    logic [1:0]      last_idx;

    logic [23:0]     sm_in;
    logic [1:0]      sm_sel;
    logic [11:0]     sm_out;
`ifdef ONEHOT_STRICT_SEL_EN
    logic            sm_err;
`endif

    int checks   = 0;
    int failures = 0;

    onehot_grant_mux #(
        .N_PORTS (NP),
        .W_DATA  (WD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .canchange (canchange),
        .req       (req),
        .gnt       (gnt),
        .data_in   (data_in),
        .data_out  (data_out),
        .last_idx  (last_idx)
    );

    onehot_sel_mux #(
        .W_INPUT  (12),
        .N_INPUTS (2)
    ) u_sm (
        .in      (sm_in),
        .sel     (sm_sel),
`ifdef ONEHOT_STRICT_SEL_EN
        .sel_err (sm_err),
`endif
        .out     (sm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: cyclic search starting after `last` when rotating, else from 0.
    function automatic int model_pick(input logic [NP-1:0] r, input logic cc, input int last);
        if (r == '0) return -1;
        if (!cc) begin
            for (int p = 0; p < NP; p++) if (r[p]) return p;
        end else begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (last + k) % NP;
                if (r[p]) return p;
            end
        end
        return -1;
    endfunction

    typedef struct {
        logic          cc;
        logic [NP-1:0] req;
        logic [NP-1:0] gnt;
        logic [WD-1:0] dout;
        logic [1:0]    last_after;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int m_last;
        int pick;
        logic [NP-1:0] e_gnt;
        logic [WD-1:0] e_dout;

        tbl[0] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 2'd0};
        tbl[1] = '{1'b0, 4'b1010, 4'b0010, 8'h22, 2'd1};
        tbl[2] = '{1'b1, 4'b1010, 4'b1000, 8'h44, 2'd3};
        tbl[3] = '{1'b1, 4'b1010, 4'b0010, 8'h22, 2'd1};
        tbl[4] = '{1'b1, 4'b1000, 4'b1000, 8'h44, 2'd3};
        tbl[5] = '{1'b1, 4'b1000, 4'b1000, 8'h44, 2'd3};
        tbl[6] = '{1'b0, 4'b0100, 4'b0100, 8'h33, 2'd2};
        tbl[7] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 2'd2};
        tbl[8] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 2'd2};
        tbl[9] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 2'd2};

        // Reset state
        rst_n     = 1'b0;
        canchange = 1'b0;
        req       = '0;
        data_in   = {8'h44, 8'h33, 8'h22, 8'h11};
        sm_in     = '0;
        sm_sel    = '0;
        @(posedge clk);
        #1;
        check("reset_gnt",  32'(gnt), 32'h0);
        check("reset_dout", 32'(data_out), 32'h0);
        check("reset_last", 32'(last_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            canchange = tbl[v].cc;
            req       = tbl[v].req;
            #1;
            check($sformatf("tbl%0d_gnt", v),  32'(gnt), 32'(tbl[v].gnt));
            check($sformatf("tbl%0d_dout", v), 32'(data_out), 32'(tbl[v].dout));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_last", v), 32'(last_idx), 32'(tbl[v].last_after));
        end

        // Asynchronous reset mid-cycle clears last_idx without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_last", 32'(last_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Standalone mux, multi-hot select
        sm_in  = {12'h0F0, 12'h00F};
        sm_sel = 2'b11;
        #1;
`ifdef ONEHOT_STRICT_SEL_EN
        check("sm_multihot_out", 32'(sm_out), 32'h0);
        check("sm_multihot_err", 32'(sm_err), 32'h1);
`else
        check("sm_multihot_out", 32'(sm_out), 32'h0FF);
`endif
        sm_sel = 2'b10;
        #1;
        check("sm_onehot_out", 32'(sm_out), 32'h0F0);
        sm_sel = 2'b00;
        #1;
        check("sm_zero_out", 32'(sm_out), 32'h0);

        // Random traffic against the model
        m_last = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            req       = NP'($urandom);
            canchange = 1'($urandom);
            data_in   = $urandom;
            pick      = model_pick(req, canchange, m_last);
            e_gnt     = '0;
            e_dout    = '0;
            if (pick >= 0) begin
                e_gnt[pick] = 1'b1;
                e_dout      = data_in[pick*WD +: WD];
                m_last      = pick;
            end
            #1;
            check("rnd_gnt",  32'(gnt), 32'(e_gnt));
            check("rnd_dout", 32'(data_out), 32'(e_dout));
            @(posedge clk);
            #1;
            check("rnd_last", 32'(last_idx), 32'(m_last));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
